// File: rtl/instruction_memory_param_pkg.sv
// ISA constants and shared types for the instruction memory.
// Contents: default word width, 5-bit opcode constants, HLT word, memory FSM state type.
// Opcode sits in the top five bits of an instruction word; HLT is the opcode with all-zero operands.
package instruction_memory_param_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int OPC_W      = 5;

  localparam logic [OPC_W-1:0] OP_HLT = 5'd18;
  localparam logic [OPC_W-1:0] OP_OUT = 5'd20;
  localparam logic [OPC_W-1:0] OP_ADD = 5'd24;
  localparam logic [OPC_W-1:0] OP_LI  = 5'd25;
  localparam logic [OPC_W-1:0] OP_SW  = 5'd26;

  localparam logic [DATA_W_DEF-1:0] HLT_WORD = {OP_HLT, {(DATA_W_DEF-OPC_W){1'b0}}};

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/instruction_memory_param_if.sv
// Fetch and load bus between the PC/fetch logic plus host loader (master) and the memory (slave).
// Fetch: fetch_en/fetch_addr in; instr/instr_valid/addr_fault/mem_ready out.
// Load: load_valid/load_addr/load_data in; load_ready/load_err out.
interface instruction_memory_param_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              addr_fault;
  logic              mem_ready;
  logic              load_valid;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              load_err;

  modport master (
    output fetch_en, fetch_addr, load_valid, load_addr, load_data,
    input  instr, instr_valid, addr_fault, mem_ready, load_ready, load_err
  );

  modport slave (
    input  fetch_en, fetch_addr, load_valid, load_addr, load_data,
    output instr, instr_valid, addr_fault, mem_ready, load_ready, load_err
  );
endinterface

// File: rtl/instruction_memory_param_boot_program_rom.sv
// Built-in boot program: combinational word index -> instruction word, HLT past the end.
// Ports: idx_i (word index), word_o (instruction word). Zero latency.
// Only instantiated when BOOT_PROGRAM_EN is defined.
module boot_program_rom
  import instruction_memory_param_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] idx_i,
  output logic [DATA_W-1:0] word_o
);

  localparam int BOOT_LEN = 6;

  // Layout: opcode in the top 5 bits, rd in the next 5, 16-bit immediate in the low bits.
  function automatic logic [DATA_W-1:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                            input logic [15:0] imm);
    logic [DATA_W-1:0] w;
    w              = '0;
    w[DATA_W-1 -: 5] = op;
    w[DATA_W-6 -: 5] = rd;
    w[15:0]        = imm;
    return w;
  endfunction

  always_comb begin
    word_o = enc(OP_HLT, 5'd0, 16'd0);
    if (idx_i < ADDR_W'(BOOT_LEN)) begin
      case (idx_i)
        ADDR_W'(0): word_o = enc(OP_LI,  5'd1, 16'h0005);  // r1 = 5
        ADDR_W'(1): word_o = enc(OP_LI,  5'd2, 16'h0007);  // r2 = 7
        ADDR_W'(2): word_o = enc(OP_ADD, 5'd3, 16'h0102);  // r3 = r1 + r2
        ADDR_W'(3): word_o = enc(OP_OUT, 5'd3, 16'h0000);  // out r3
        ADDR_W'(4): word_o = enc(OP_SW,  5'd3, 16'h0020);  // mem[0x20] = r3
        default:    word_o = enc(OP_HLT, 5'd0, 16'd0);
      endcase
    end
  end

endmodule

// File: rtl/instruction_memory_param.sv
// Instruction memory: DEPTH words, registered 1-cycle fetch, valid/ready load port, init sweep.
// Ports: clock, reset (sync, active-high), bus (slave modport: fetch + load channels).
// Optional BOOT_PROGRAM_EN: sweep writes the boot program instead of all-HLT.
module instruction_memory_param
  import instruction_memory_param_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  instruction_memory_param_if.slave  bus
);

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH-1);
  localparam logic [DATA_W-1:0] HLT_W    = {OP_HLT, {(DATA_W-OPC_W){1'b0}}};

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH-1:0];

  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic              lerr_q,  lerr_d;

  logic              run;
  logic              fetch_oob;
  logic              load_oob;
  logic              load_acc;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_dat;
  logic [DATA_W-1:0] fill_word;

`ifdef BOOT_PROGRAM_EN
  boot_program_rom #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_boot_rom (
    .idx_i  (ADDR_W'(cnt_q)),
    .word_o (fill_word)
  );
`else
  assign fill_word = HLT_W;
`endif

  // Range checks use one extra bit so DEPTH == 2**ADDR_W compares correctly.
  assign fetch_oob = {1'b0, bus.fetch_addr} >= DEPTH_X;
  assign load_oob  = {1'b0, bus.load_addr}  >= DEPTH_X;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: sweep DEPTH words, then stay in RUN until reset
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_IDX) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    end
  end

  // Outputs and single write-port mux: sweep owns the port in INIT, loader in RUN
  always_comb begin
    run      = (state_q == ST_RUN);
    load_acc = run && bus.load_valid;
    wr_en    = 1'b0;
    wr_idx   = cnt_q;
    wr_dat   = fill_word;
    if (!run) begin
      wr_en = 1'b1;
    end else if (load_acc && !load_oob) begin
      wr_en  = 1'b1;
      wr_idx = bus.load_addr[IDX_W-1:0];
      wr_dat = bus.load_data;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_dat;
    end
  end

  // Fetch result; the array is read with the pre-write contents, so a same-cycle
  // load to the fetched address returns the old word.
  always_comb begin
    instr_d = instr_q;
    valid_d = 1'b0;
    fault_d = 1'b0;
    lerr_d  = load_acc && load_oob;
    if (run && bus.fetch_en) begin
      valid_d = 1'b1;
      fault_d = fetch_oob;
      instr_d = fetch_oob ? HLT_W : mem_q[bus.fetch_addr[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      instr_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      lerr_q  <= lerr_d;
    end
  end

  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.addr_fault  = fault_q;
  assign bus.mem_ready   = run;
  assign bus.load_ready  = run;
  assign bus.load_err    = lerr_q;

endmodule

// File: tb/tb_instruction_memory_param.sv
module tb_instruction_memory_param;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 64;
  localparam logic [31:0] HLT = 32'h9000_0000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  instruction_memory_param_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  instruction_memory_param #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] exp_instr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected post-sweep contents of word i.
  function automatic logic [31:0] fill_word(input int i);
`ifdef BOOT_PROGRAM_EN
    case (i)
      0:       return 32'hC840_0005;
      1:       return 32'hC880_0007;
      2:       return 32'hC0C0_0102;
      3:       return 32'hA0C0_0000;
      4:       return 32'hD0C0_0020;
      default: return HLT;
    endcase
`else
    return HLT;
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fetch_en   = 1'b0;
    bus.fetch_addr = '0;
    bus.load_valid = 1'b0;
    bus.load_addr  = '0;
    bus.load_data  = '0;
  endtask

  // One RUN-mode cycle checked against the word-array model.
  task automatic run_cycle(input logic fe, input int fa, input logic lv, input int la,
                           input logic [31:0] ld);
    logic e_err;
    bus.fetch_en   = fe;
    bus.fetch_addr = ADDR_W'(fa);
    bus.load_valid = lv;
    bus.load_addr  = ADDR_W'(la);
    bus.load_data  = ld;
    if (fe) exp_instr = (fa >= DEPTH) ? HLT : model[fa];
    e_err = lv && (la >= DEPTH);
    tick();
    check("instr_valid", bus.instr_valid, fe);
    check("instr", bus.instr, exp_instr);
    if (fe) check("addr_fault", bus.addr_fault, fa >= DEPTH);
    check("load_err", bus.load_err, e_err);
    check("load_ready", bus.load_ready, 1'b1);
    if (lv && la < DEPTH) model[la] = ld;
    idle_inputs();
  endtask

  task automatic sweep_and_check(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      // Requests during the sweep must be ignored.
      bus.fetch_en   = 1'b1;
      bus.fetch_addr = ADDR_W'(i);
      bus.load_valid = 1'b1;
      bus.load_addr  = '0;
      bus.load_data  = 32'hDEAD_BEEF;
      tick();
      check({tag, "_mem_ready"}, bus.mem_ready, i == DEPTH - 1);
      check({tag, "_load_ready"}, bus.load_ready, i == DEPTH - 1);
      check({tag, "_valid"}, bus.instr_valid, 1'b0);
    end
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) model[i] = fill_word(i);
  endtask

  initial begin
    idle_inputs();
    exp_instr = '0;

    // Reset values
    reset = 1'b1;
    tick();
    check("rst_instr", bus.instr, 32'h0);
    check("rst_valid", bus.instr_valid, 1'b0);
    check("rst_fault", bus.addr_fault, 1'b0);
    check("rst_mem_ready", bus.mem_ready, 1'b0);
    check("rst_load_ready", bus.load_ready, 1'b0);
    check("rst_load_err", bus.load_err, 1'b0);
    reset = 1'b0;

    sweep_and_check("init");

`ifdef BOOT_PROGRAM_EN
    for (int i = 0; i <= 6; i++) begin
      run_cycle(1'b1, i, 1'b0, 0, 32'h0);
      check("boot_word", bus.instr, fill_word(i));
    end
    check("boot_end_hlt", bus.instr, HLT);
`endif

    // Fetch after sweep
    run_cycle(1'b1, 5, 1'b0, 0, 32'h0);
    check("t1_fetch5", bus.instr, fill_word(5));

    // Load then fetch
    run_cycle(1'b0, 0, 1'b1, 3, 32'hC840_0001);
    run_cycle(1'b1, 3, 1'b0, 0, 32'h0);
    check("t2_load3", bus.instr, 32'hC840_0001);

    // Same-cycle load and fetch: read-first
    run_cycle(1'b1, 7, 1'b1, 7, 32'h1234_5678);
    check("t3_old", bus.instr, fill_word(7));
    run_cycle(1'b1, 7, 1'b0, 0, 32'h0);
    check("t3_new", bus.instr, 32'h1234_5678);

    // Out-of-range fetch and load
    run_cycle(1'b1, 64, 1'b0, 0, 32'h0);
    check("t4_hlt", bus.instr, HLT);
    check("t4_fault", bus.addr_fault, 1'b1);
    run_cycle(1'b0, 0, 1'b1, 70, 32'hFFFF_FFFF);
    check("t4_err_pulse", bus.load_err, 1'b1);
    run_cycle(1'b0, 0, 1'b0, 0, 32'h0);
    check("t4_err_clear", bus.load_err, 1'b0);
    run_cycle(1'b1, 6, 1'b0, 0, 32'h0);
    check("t4_addr6", bus.instr, fill_word(6));

    // Randomised traffic, addresses biased so collisions and faults happen
    for (int n = 0; n < 400; n++) begin
      logic fe, lv;
      int   fa, la;
      fe = 1'($urandom_range(0, 1));
      lv = 1'($urandom_range(0, 1));
      fa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(64, 90)) : int'($urandom_range(0, 15));
      la = ($urandom_range(0, 4) == 0) ? int'($urandom_range(64, 90)) : int'($urandom_range(0, 15));
      run_cycle(fe, fa, lv, la, $urandom);
    end

    // Reset mid-RUN with a fetch in flight
    run_cycle(1'b0, 0, 1'b1, 3, 32'hC840_0001);
    bus.fetch_en   = 1'b1;
    bus.fetch_addr = ADDR_W'(3);
    reset = 1'b1;
    tick();
    check("t5_valid", bus.instr_valid, 1'b0);
    check("t5_mem_ready", bus.mem_ready, 1'b0);
    check("t5_instr", bus.instr, 32'h0);
    reset = 1'b0;
    exp_instr = '0;
    sweep_and_check("resweep");
    run_cycle(1'b1, 3, 1'b0, 0, 32'h0);
    check("t5_erased", bus.instr, fill_word(3));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
